dcpu_lsu: RTL and testbench

Parametrised load/store unit between the dcpu execute stage and the Wishbone-style bus. Accepts one byte/half/word access per request, splits it into bus beats sized by `BUS_W`, steers byte lanes, zero- or sign-extends read data and reports completion or error. It replaces the inline EXECUTE1/EXECUTE2 memory sequencing of the core and supports 16- and 32-bit buses with arbitrary wait states.

---
 rtl/dcpu_lsu.sv | 256 +++++++++++++++++++++++++
 tb/tb_dcpu_lsu.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcpu_lsu.sv
// dcpu load/store unit: splits byte/half/word accesses into bus beats, steers
// big-endian byte lanes, extends load data and reports done/error.
// Optional per-beat timeout enabled by defining DCPU_LSU_TIMEOUT_EN.
module dcpu_lsu #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned BUS_W   = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_req,
  input  logic                 i_we,
  input  logic [1:0]           i_size,
  input  logic                 i_signed,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [31:0]          i_wdat,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [31:0]          o_rdat,
  output logic                 o_cyc,
  output logic [BUS_W/8-1:0]   o_stb,
  output logic                 o_we,
  output logic [ADDR_W-1:0]    o_addr,
  output logic [BUS_W-1:0]     o_dat,
  input  logic                 i_ack,
  input  logic [BUS_W-1:0]     i_dat
);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e              state_q, state_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic                beat_q, beat_d;
  logic                two_q, two_d;
  logic                busy_d, done_d, err_d, cyc_d, we_d;
  logic [BUS_W/8-1:0]  stb_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [BUS_W-1:0]    dat_d;
  logic [31:0]         rdat_d, ld_ext;

  // Bus-width specific lane steering
  logic [BUS_W/8-1:0]  req_stb;
  logic [BUS_W-1:0]    req_dat, beat1_dat;
  logic                req_two;
  logic [31:0]         ld_raw;
  logic                tmo_hit;

  logic bad_req;
  assign bad_req = (i_size == 2'b11) || ((i_size == 2'b01) && i_addr[0]) ||
                   ((i_size == 2'b10) && (i_addr[1:0] != 2'b00));

  if (BUS_W == 16) begin : g_bus16
    logic [15:0] hi_q, wlo_q;

    // Keep the low store half for beat 1 and the high load half from beat 0
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        hi_q  <= '0;
        wlo_q <= '0;
      end else begin
        if (state_q == StIdle && i_req) wlo_q <= i_wdat[15:0];
        if (o_cyc && i_ack)             hi_q  <= i_dat;
      end
    end

    // Lane mapping for a 16-bit bus; lowest address is the MSB lane
    always_comb begin
      req_two   = (i_size == 2'b10);
      beat1_dat = wlo_q;
      unique case (i_size)
        2'b00:   begin
          req_stb = i_addr[0] ? 2'b01 : 2'b10;
          req_dat = {2{i_wdat[7:0]}};
        end
        2'b01:   begin
          req_stb = 2'b11;
          req_dat = i_wdat[15:0];
        end
        default: begin
          req_stb = 2'b11;
          req_dat = i_wdat[31:16];
        end
      endcase
      unique case (size_q)
        2'b00:   ld_raw = {24'h0, (o_addr[0] ? i_dat[7:0] : i_dat[15:8])};
        2'b01:   ld_raw = {16'h0, i_dat};
        default: ld_raw = {hi_q, i_dat};
      endcase
    end
  end else begin : g_bus32
    // Lane mapping for a 32-bit bus; every access is a single beat
    always_comb begin
      req_two   = 1'b0;
      beat1_dat = '0;
      unique case (i_size)
        2'b00:   begin
          req_stb = 4'b1000 >> i_addr[1:0];
          req_dat = {4{i_wdat[7:0]}};
        end
        2'b01:   begin
          req_stb = i_addr[1] ? 4'b0011 : 4'b1100;
          req_dat = {2{i_wdat[15:0]}};
        end
        default: begin
          req_stb = 4'b1111;
          req_dat = i_wdat;
        end
      endcase
      unique case (size_q)
        2'b00: begin
          unique case (o_addr[1:0])
            2'b00:   ld_raw = {24'h0, i_dat[31:24]};
            2'b01:   ld_raw = {24'h0, i_dat[23:16]};
            2'b10:   ld_raw = {24'h0, i_dat[15:8]};
            default: ld_raw = {24'h0, i_dat[7:0]};
          endcase
        end
        2'b01:   ld_raw = {16'h0, (o_addr[1] ? i_dat[15:0] : i_dat[31:16])};
        default: ld_raw = i_dat;
      endcase
    end
  end

`ifdef DCPU_LSU_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] tmo_q, tmo_d;

  // Per-beat wait counter; cleared outside BUS and on every ack
  always_comb begin
    tmo_d = tmo_q;
    if (state_q != StBus || i_ack) tmo_d = '0;
    else                           tmo_d = tmo_q + 1'b1;
  end

  // Wait counter register
  always_ff @(posedge i_clk) begin
    if (i_reset) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end

  assign tmo_hit = (tmo_q == CntW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Extend the assembled load value
  always_comb begin
    unique case (size_q)
      2'b00:   ld_ext = {{24{signed_q & ld_raw[7]}}, ld_raw[7:0]};
      2'b01:   ld_ext = {{16{signed_q & ld_raw[15]}}, ld_raw[15:0]};
      default: ld_ext = ld_raw;
    endcase
  end

  // Next state and next registered outputs
  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    signed_d = signed_q;
    beat_d   = beat_q;
    two_d    = two_q;
    cyc_d    = o_cyc;
    stb_d    = o_stb;
    we_d     = o_we;
    addr_d   = o_addr;
    dat_d    = o_dat;
    rdat_d   = o_rdat;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_req) begin
          size_d   = i_size;
          signed_d = i_signed;
          beat_d   = 1'b0;
          two_d    = req_two;
          if (bad_req) begin
            state_d = StResp;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = StBus;
            cyc_d   = 1'b1;
            stb_d   = req_stb;
            we_d    = i_we;
            addr_d  = i_addr;
            dat_d   = req_dat;
          end
        end
      end
      StBus: begin
        if (i_ack) begin
          if (two_q && !beat_q) begin
            beat_d = 1'b1;
            addr_d = o_addr + ADDR_W'(2);
            dat_d  = beat1_dat;
          end else begin
            state_d = StResp;
            cyc_d   = 1'b0;
            stb_d   = '0;
            we_d    = 1'b0;
            done_d  = 1'b1;
            if (!o_we) rdat_d = ld_ext;
          end
        end else if (tmo_hit) begin
          state_d = StResp;
          cyc_d   = 1'b0;
          stb_d   = '0;
          we_d    = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= StIdle;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      beat_q   <= 1'b0;
      two_q    <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
      o_cyc    <= 1'b0;
      o_stb    <= '0;
      o_we     <= 1'b0;
      o_addr   <= '0;
      o_dat    <= '0;
      o_rdat   <= '0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      beat_q   <= beat_d;
      two_q    <= two_d;
      o_busy   <= busy_d;
      o_done   <= done_d;
      o_err    <= err_d;
      o_cyc    <= cyc_d;
      o_stb    <= stb_d;
      o_we     <= we_d;
      o_addr   <= addr_d;
      o_dat    <= dat_d;
      o_rdat   <= rdat_d;
    end
  end

endmodule

// File: tb/tb_dcpu_lsu.sv
// Directed self-checking bench for dcpu_lsu (16-bit bus instance plus a
// 32-bit instance with TIMEOUT=4).
module tb_dcpu_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, req32 = 1'b0;
  logic        we = 1'b0, sgn = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdat = '0;

  logic        busy, done, err, cyc, owe;
  logic [31:0] rdat, oaddr;
  logic [1:0]  stb;
  logic [15:0] odat, idat16;
  logic        ack16;

  logic        busy32, done32, err32, cyc32, owe32;
  logic [31:0] rdat32, oaddr32, odat32;
  logic [3:0]  stb32;
  logic        ack32 = 1'b0;
  logic [31:0] idat32 = '0;

  // Bus responder state
  logic        rsp_en = 1'b1, rsp_ack = 1'b0, man_ack = 1'b0;
  logic [15:0] rsp_idat = '0, man_idat = '0, rsp_d0 = '0, rsp_d1 = '0;
  int          rsp_waits = 0, rsp_wcnt = 0, rsp_beat = 0;
  logic [31:0] log_addr [2];
  logic [15:0] log_dat  [2];
  logic [1:0]  log_stb  [2];
  logic        log_we   [2];

  int errors = 0, checks = 0;
  int cyc_n, done_n, done_cyc;
  logic err_s;
  logic [31:0] rdat_s;

  assign ack16  = rsp_en ? rsp_ack  : man_ack;
  assign idat16 = rsp_en ? rsp_idat : man_idat;

  always #5 clk = ~clk;

  dcpu_lsu u_dut (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_we(we), .i_size(size), .i_signed(sgn),
    .i_addr(addr), .i_wdat(wdat), .o_busy(busy), .o_done(done), .o_err(err), .o_rdat(rdat),
    .o_cyc(cyc), .o_stb(stb), .o_we(owe), .o_addr(oaddr), .o_dat(odat), .i_ack(ack16),
    .i_dat(idat16)
  );

  dcpu_lsu #(.ADDR_W(32), .BUS_W(32), .TIMEOUT(4)) u_dut32 (
    .i_clk(clk), .i_reset(rst), .i_req(req32), .i_we(we), .i_size(size), .i_signed(sgn),
    .i_addr(addr), .i_wdat(wdat), .o_busy(busy32), .o_done(done32), .o_err(err32),
    .o_rdat(rdat32), .o_cyc(cyc32), .o_stb(stb32), .o_we(owe32), .o_addr(oaddr32),
    .o_dat(odat32), .i_ack(ack32), .i_dat(idat32)
  );

  // Acks each beat after rsp_waits wait cycles and logs the beat outputs
  always @(negedge clk) begin
    if (!cyc) begin
      rsp_beat = 0;
      rsp_wcnt = 0;
      rsp_ack  = 1'b0;
    end else begin
      if (rsp_ack) begin
        rsp_beat = rsp_beat + 1;
        rsp_wcnt = 0;
      end
      rsp_ack = 1'b0;
      if (rsp_wcnt == rsp_waits) begin
        rsp_ack  = 1'b1;
        rsp_idat = (rsp_beat[0]) ? rsp_d1 : rsp_d0;
        log_addr[rsp_beat[0]] = oaddr;
        log_dat[rsp_beat[0]]  = odat;
        log_stb[rsp_beat[0]]  = stb;
        log_we[rsp_beat[0]]   = owe;
      end else begin
        rsp_wcnt = rsp_wcnt + 1;
      end
    end
  end

  // Issues one request on the 16-bit DUT and gathers cycle statistics
  task automatic run_access(input logic we_v, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd, input int waits,
                            input logic [15:0] d0, input logic [15:0] d1, input logic dup);
    rsp_en = 1'b1; rsp_waits = waits; rsp_d0 = d0; rsp_d1 = d1;
    cyc_n = 0; done_n = 0; done_cyc = -1; err_s = 1'b0;
    @(negedge clk);
    we = we_v; size = sz; sgn = sg; addr = a; wdat = wd; req = 1'b1;
    @(negedge clk);
    req = dup;
    for (int c = 1; c <= 40; c++) begin
      if (cyc) cyc_n++;
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = c;
        err_s = err;
      end
      rdat_s = rdat;
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
      @(negedge clk);
      req = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (cyc !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b want 0", cyc); end
    checks++; if (stb !== 2'b00) begin errors++; $display("FAIL reset_stb: got %b want 00", stb); end
    checks++; if (owe !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", owe); end
    checks++; if (oaddr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", oaddr); end
    checks++; if (odat !== 16'h0) begin errors++; $display("FAIL reset_dat: got %h want 0", odat); end
    checks++; if (rdat !== 32'h0) begin errors++; $display("FAIL reset_rdat: got %h want 0", rdat); end
    rst = 1'b0;
  endtask

  task automatic test_byte_half_loads;
    run_access(1'b0, 2'b00, 1'b0, 32'h1001, 32'h0, 0, 16'hAB5C, 16'h0, 1'b0);
    checks++; if (log_stb[0] !== 2'b01) begin errors++; $display("FAIL bl_stb: got %b want 01", log_stb[0]); end
    checks++; if (log_addr[0] !== 32'h1001) begin errors++; $display("FAIL bl_addr: got %h want 00001001", log_addr[0]); end
    checks++; if (rdat_s !== 32'h0000005C) begin errors++; $display("FAIL bl_rdat: got %h want 0000005c", rdat_s); end
    checks++; if (done_cyc !== 2) begin errors++; $display("FAIL bl_latency: got %0d want 2", done_cyc); end
    checks++; if (err_s !== 1'b0) begin errors++; $display("FAIL bl_err: got %b want 0", err_s); end
    run_access(1'b0, 2'b00, 1'b1, 32'h1001, 32'h0, 0, 16'h00F0, 16'h0, 1'b0);
    checks++; if (rdat_s !== 32'hFFFFFFF0) begin errors++; $display("FAIL bl_signed: got %h want fffffff0", rdat_s); end
    run_access(1'b0, 2'b00, 1'b1, 32'h1000, 32'h0, 0, 16'h8012, 16'h0, 1'b0);
    checks++; if (log_stb[0] !== 2'b10) begin errors++; $display("FAIL bl_hi_stb: got %b want 10", log_stb[0]); end
    checks++; if (rdat_s !== 32'hFFFFFF80) begin errors++; $display("FAIL bl_hi_signed: got %h want ffffff80", rdat_s); end
    run_access(1'b0, 2'b01, 1'b1, 32'h1002, 32'h0, 0, 16'h8001, 16'h0, 1'b0);
    checks++; if (rdat_s !== 32'hFFFF8001) begin errors++; $display("FAIL hl_signed: got %h want ffff8001", rdat_s); end
    run_access(1'b0, 2'b01, 1'b0, 32'h1002, 32'h0, 0, 16'h8001, 16'h0, 1'b0);
    checks++; if (rdat_s !== 32'h00008001) begin errors++; $display("FAIL hl_unsigned: got %h want 00008001", rdat_s); end
  endtask

  task automatic test_word_store;
    run_access(1'b1, 2'b10, 1'b0, 32'h2000, 32'h12345678, 0, 16'h0, 16'h0, 1'b0);
    checks++; if (log_addr[0] !== 32'h2000) begin errors++; $display("FAIL ws_addr0: got %h want 00002000", log_addr[0]); end
    checks++; if (log_dat[0] !== 16'h1234) begin errors++; $display("FAIL ws_dat0: got %h want 1234", log_dat[0]); end
    checks++; if (log_stb[0] !== 2'b11) begin errors++; $display("FAIL ws_stb0: got %b want 11", log_stb[0]); end
    checks++; if (log_we[0] !== 1'b1) begin errors++; $display("FAIL ws_we0: got %b want 1", log_we[0]); end
    checks++; if (log_addr[1] !== 32'h2002) begin errors++; $display("FAIL ws_addr1: got %h want 00002002", log_addr[1]); end
    checks++; if (log_dat[1] !== 16'h5678) begin errors++; $display("FAIL ws_dat1: got %h want 5678", log_dat[1]); end
    checks++; if (log_stb[1] !== 2'b11) begin errors++; $display("FAIL ws_stb1: got %b want 11", log_stb[1]); end
    checks++; if (cyc_n !== 2) begin errors++; $display("FAIL ws_cyc_cycles: got %0d want 2", cyc_n); end
    checks++; if (done_cyc !== 3) begin errors++; $display("FAIL ws_latency: got %0d want 3", done_cyc); end
    checks++; if (err_s !== 1'b0) begin errors++; $display("FAIL ws_err: got %b want 0", err_s); end
  endtask

  task automatic test_wait_states;
    run_access(1'b0, 2'b10, 1'b0, 32'h2100, 32'h0, 3, 16'hDEAD, 16'hBEEF, 1'b0);
    checks++; if (done_n !== 1) begin errors++; $display("FAIL wt_done_count: got %0d want 1", done_n); end
    checks++; if (rdat_s !== 32'hDEADBEEF) begin errors++; $display("FAIL wt_rdat: got %h want deadbeef", rdat_s); end
    checks++; if (cyc_n !== 8) begin errors++; $display("FAIL wt_cyc_cycles: got %0d want 8", cyc_n); end
    checks++; if (done_cyc !== 9) begin errors++; $display("FAIL wt_latency: got %0d want 9", done_cyc); end
  endtask

  task automatic test_errors;
    run_access(1'b0, 2'b01, 1'b0, 32'h3001, 32'h0, 0, 16'h1111, 16'h0, 1'b0);
    checks++; if (cyc_n !== 0) begin errors++; $display("FAIL em_cyc: got %0d want 0", cyc_n); end
    checks++; if (done_cyc !== 1) begin errors++; $display("FAIL em_latency: got %0d want 1", done_cyc); end
    checks++; if (err_s !== 1'b1) begin errors++; $display("FAIL em_err: got %b want 1", err_s); end
    checks++; if (rdat_s !== 32'hDEADBEEF) begin errors++; $display("FAIL em_rdat: got %h want deadbeef", rdat_s); end
    run_access(1'b0, 2'b11, 1'b0, 32'h3000, 32'h0, 0, 16'h2222, 16'h0, 1'b0);
    checks++; if (cyc_n !== 0) begin errors++; $display("FAIL er_cyc: got %0d want 0", cyc_n); end
    checks++; if (done_cyc !== 1) begin errors++; $display("FAIL er_latency: got %0d want 1", done_cyc); end
    checks++; if (err_s !== 1'b1) begin errors++; $display("FAIL er_err: got %b want 1", err_s); end
    checks++; if (rdat_s !== 32'hDEADBEEF) begin errors++; $display("FAIL er_rdat: got %h want deadbeef", rdat_s); end
  endtask

  task automatic test_reset_mid;
    int dn;
    rsp_en = 1'b0; man_ack = 1'b0;
    @(negedge clk);
    we = 1'b0; size = 2'b10; sgn = 1'b0; addr = 32'h5000; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    checks++; if (cyc !== 1'b1) begin errors++; $display("FAIL rm_cyc_b0: got %b want 1", cyc); end
    man_ack = 1'b1; man_idat = 16'h1111;
    @(negedge clk);
    man_ack = 1'b0;
    checks++; if (oaddr !== 32'h5002) begin errors++; $display("FAIL rm_addr_b1: got %h want 00005002", oaddr); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (cyc !== 1'b0) begin errors++; $display("FAIL rm_cyc: got %b want 0", cyc); end
    checks++; if (stb !== 2'b00) begin errors++; $display("FAIL rm_stb: got %b want 00", stb); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", busy); end
    dn = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) dn++;
      @(negedge clk);
    end
    checks++; if (dn !== 0) begin errors++; $display("FAIL rm_no_done: got %0d want 0", dn); end
    run_access(1'b0, 2'b00, 1'b0, 32'h1000, 32'h0, 0, 16'h4200, 16'h0, 1'b0);
    checks++; if (rdat_s !== 32'h00000042) begin errors++; $display("FAIL rm_after_rdat: got %h want 00000042", rdat_s); end
    checks++; if (done_cyc !== 2) begin errors++; $display("FAIL rm_after_latency: got %0d want 2", done_cyc); end
  endtask

  task automatic test_ignored_req;
    run_access(1'b0, 2'b00, 1'b0, 32'h1001, 32'h0, 2, 16'h0011, 16'h0, 1'b1);
    checks++; if (done_n !== 1) begin errors++; $display("FAIL ir_done_count: got %0d want 1", done_n); end
    checks++; if (cyc_n !== 3) begin errors++; $display("FAIL ir_cyc_cycles: got %0d want 3", cyc_n); end
    checks++; if (rdat_s !== 32'h00000011) begin errors++; $display("FAIL ir_rdat: got %h want 00000011", rdat_s); end
  endtask

  task automatic test_bus32;
    int cn, dc;
    logic e;
    @(negedge clk);
    we = 1'b1; size = 2'b00; sgn = 1'b0; addr = 32'h4002; wdat = 32'h00000077; req32 = 1'b1;
    @(negedge clk);
    req32 = 1'b0;
    checks++; if (stb32 !== 4'b0010) begin errors++; $display("FAIL b32_stb: got %b want 0010", stb32); end
    checks++; if (odat32 !== 32'h77777777) begin errors++; $display("FAIL b32_dat: got %h want 77777777", odat32); end
    checks++; if (oaddr32 !== 32'h4002) begin errors++; $display("FAIL b32_addr: got %h want 00004002", oaddr32); end
    checks++; if (owe32 !== 1'b1) begin errors++; $display("FAIL b32_we: got %b want 1", owe32); end
    cn = 0; dc = -1; e = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (cyc32) cn++;
      if (done32 && dc < 0) begin dc = c; e = err32; end
      @(negedge clk);
    end
`ifdef DCPU_LSU_TIMEOUT_EN
    checks++; if (cn !== 4) begin errors++; $display("FAIL b32_tmo_cyc: got %0d want 4", cn); end
    checks++; if (dc !== 5) begin errors++; $display("FAIL b32_tmo_done: got %0d want 5", dc); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL b32_tmo_err: got %b want 1", e); end
    checks++; if (stb32 !== 4'b0000) begin errors++; $display("FAIL b32_tmo_stb: got %b want 0000", stb32); end
`else
    checks++; if (cn !== 10) begin errors++; $display("FAIL b32_wait_cyc: got %0d want 10", cn); end
    checks++; if (dc !== -1) begin errors++; $display("FAIL b32_wait_done: got %0d want none", dc); end
    ack32 = 1'b1;
    @(negedge clk);
    ack32 = 1'b0;
    checks++; if (done32 !== 1'b1) begin errors++; $display("FAIL b32_ack_done: got %b want 1", done32); end
    checks++; if (err32 !== 1'b0) begin errors++; $display("FAIL b32_ack_err: got %b want 0", err32); end
`endif
  endtask

  initial begin
    test_reset();
    test_byte_half_loads();
    test_word_store();
    test_wait_states();
    test_errors();
    test_reset_mid();
    test_ignored_req();
    test_bus32();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
